// File: rtl/fib_pkg.sv
// fib_pkg: shared types, constants and a golden Fibonacci helper for the
// fib_seq_engine block.
//   fib_state_t     : engine FSM encoding (IDLE -> RUN -> DONE -> IDLE)
//   FIB_MAX_IDX_32  : largest k whose fib(k) fits a signed 32-bit value
//   fib_ref(k)      : exact fib(k) in 64 bits (exact for k <= 93)
package fib_pkg;

   typedef enum logic [1:0] {IDLE, RUN, DONE} fib_state_t;

   localparam int FIB_MAX_IDX_32 = 46;

   function automatic logic [63:0] fib_ref(input int unsigned k);
      logic [63:0] a;
      logic [63:0] b;
      logic [63:0] t;
      a = 64'd0;
      b = 64'd1;
      for (int unsigned i = 0; i < k; i++) begin
         t = a + b;
         a = b;
         b = t;
      end
      return a;
   endfunction

endpackage

// File: rtl/fib_sat_add.sv
// fib_sat_add: combinational final stage of the engine, off + fib.
//   off      in  WIDTH  signed offset
//   fib      in  WIDTH  fib accumulator value (may have wrapped)
//   fib_ovf  in  1      fib itself already left the signed range
//   sum_out  out WIDTH  wrapped or saturated result
//   ovf      out 1      fib_ovf or the add not representable in WIDTH bits
module fib_sat_add
   import fib_pkg::*;
#(
   parameter int WIDTH    = 32,
   parameter int SATURATE = 0
) (
   input  logic [WIDTH-1:0] off,
   input  logic [WIDTH-1:0] fib,
   input  logic             fib_ovf,
   output logic [WIDTH-1:0] sum_out,
   output logic             ovf
);

   localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

   logic [WIDTH:0] sum;
   logic           sum_ovf;

   // One guard bit: the add overflowed when the guard and sign bits disagree.
   assign sum     = {off[WIDTH-1], off} + {fib[WIDTH-1], fib};
   assign sum_ovf = sum[WIDTH] ^ sum[WIDTH-1];
   assign ovf     = fib_ovf | sum_ovf;

   always_comb begin
      sum_out = sum[WIDTH-1:0];
      if (SATURATE != 0) begin
         // A true fib beyond the range is always positive, so clamp high.
         if (fib_ovf)
            sum_out = SMAX;
         else if (sum_ovf)
            sum_out = sum[WIDTH] ? SMIN : SMAX;
      end
   end

endmodule

// File: rtl/fib_seq_engine.sv
// fib_seq_engine: iterative result = off + fib(k) behind a start/busy/done
// handshake; one Fibonacci step per clock, done at accept + k + 2.
//   clk       in   1      clock
//   rst       in   1      synchronous active-high reset
//   start     in   1      request strobe, honoured only in IDLE
//   k         in   IDX_W  Fibonacci index, captured on accept
//   off       in   WIDTH  signed offset, captured on accept
//   busy      out  1      high from the cycle after accept until done
//   done      out  1      one-cycle pulse with result/overflow update
//   result    out  WIDTH  off + fib(k), wrapped or saturated; held until next done
//   overflow  out  1      fib(k) or off+fib(k) left the signed range
module fib_seq_engine
   import fib_pkg::*;
#(
   parameter int WIDTH    = 32,
   parameter int IDX_W    = 6,
   parameter int SATURATE = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [IDX_W-1:0] k,
   input  logic [WIDTH-1:0] off,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             overflow
);

   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   fib_state_t       state;
   logic [WIDTH-1:0] a, b;
   logic [IDX_W-1:0] cnt;
   logic [WIDTH-1:0] off_q;
   // ovf_a / ovf_b track whether a / b hold a value that left the range.
   // The sum lands in b and only becomes fib(k) one step later, so the
   // reported flag follows a; this keeps fib(k+1) out of the verdict.
   logic             ovf_a, ovf_b;

   logic [WIDTH:0]   ab_sum;
   logic             ab_ovf;
   logic [WIDTH-1:0] fin_res;
   logic             fin_ovf;

   // a and b are non-negative until a flag is set, so an unsigned sum above
   // the signed max is the only overflow case that matters.
   assign ab_sum = {1'b0, a} + {1'b0, b};
   assign ab_ovf = ab_sum[WIDTH] | ab_sum[WIDTH-1];

   fib_sat_add #(
      .WIDTH    (WIDTH),
      .SATURATE (SATURATE)
   ) u_sat_add (
      .off     (off_q),
      .fib     (a),
      .fib_ovf (ovf_a),
      .sum_out (fin_res),
      .ovf     (fin_ovf)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         busy     <= 1'b0;
         done     <= 1'b0;
         result   <= '0;
         overflow <= 1'b0;
         a        <= '0;
         b        <= ONE;
         cnt      <= '0;
         off_q    <= '0;
         ovf_a    <= 1'b0;
         ovf_b    <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  off_q <= off;
                  cnt   <= k;
                  a     <= '0;
                  b     <= ONE;
                  ovf_a <= 1'b0;
                  ovf_b <= 1'b0;
                  busy  <= 1'b1;
                  state <= RUN;
               end
            end
            RUN: begin
               if (cnt != '0) begin
                  a     <= b;
                  b     <= ab_sum[WIDTH-1:0];
                  cnt   <= cnt - IDX_W'(1);
                  ovf_a <= ovf_b;
                  ovf_b <= ovf_b | ab_ovf;
               end else begin
                  result   <= fin_res;
                  overflow <= fin_ovf;
                  done     <= 1'b1;
                  busy     <= 1'b0;
                  state    <= DONE;
               end
            end
            DONE: begin
               // start is not looked at here; the next accept is from IDLE.
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fib_seq_engine.sv
module tb_fib_seq_engine;
   import fib_pkg::*;

   localparam int W  = 32;
   localparam int KW = 6;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [KW-1:0] k_i;
   logic [W-1:0]  off_i;
   logic          busy0, done0, ovf0, busy1, done1, ovf1;
   logic [W-1:0]  res0, res1;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   fib_seq_engine #(.WIDTH(W), .IDX_W(KW), .SATURATE(0)) dut_wrap (
      .clk(clk), .rst(rst), .start(start), .k(k_i), .off(off_i),
      .busy(busy0), .done(done0), .result(res0), .overflow(ovf0));

   fib_seq_engine #(.WIDTH(W), .IDX_W(KW), .SATURATE(1)) dut_sat (
      .clk(clk), .rst(rst), .start(start), .k(k_i), .off(off_i),
      .busy(busy1), .done(done1), .result(res1), .overflow(ovf1));

   typedef struct {
      logic [KW-1:0] k;
      logic [W-1:0]  off;
      logic [W-1:0]  r0;
      logic          o0;
      logic [W-1:0]  r1;
      logic          o1;
   } vec_t;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Reference: exact integer arithmetic on fib(k) and off, then the
   // wrap/saturate rules applied to the true mathematical values.
   task automatic model(input logic [KW-1:0] kk, input logic [W-1:0] oo, input bit sat,
                        output logic [W-1:0] r, output logic o);
      logic [63:0] f;
      logic [W-1:0] fw;
      longint fs, s, smax, smin;
      bit fov, sov;
      smax = 64'sh7FFF_FFFF;
      smin = -64'sh8000_0000;
      f    = fib_ref(int'(kk));
      fov  = (f > 64'h7FFF_FFFF);
      fw   = f[W-1:0];
      fs   = longint'($signed(fw));
      s    = longint'($signed(oo)) + fs;
      sov  = (s > smax) || (s < smin);
      o    = fov | sov;
      if (sat && fov)       r = 32'h7FFF_FFFF;
      else if (sat && sov)  r = (s > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
      else                  r = s[W-1:0];
   endtask

   // Drives a request at a negedge; returns at the negedge where done is seen.
   task automatic run_req(input logic [KW-1:0] kk, input logic [W-1:0] oo,
                          output int lat, output bit busy_ok);
      k_i = kk; off_i = oo; start = 1'b1;
      busy_ok = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat = 1;
      while (!done0 && lat < 200) begin
         if (!busy0 || !busy1) busy_ok = 1'b0;
         @(negedge clk);
         lat++;
      end
      if (busy0 || busy1 || !done1) busy_ok = 1'b0;
   endtask

   task automatic check_req(input string nm, input logic [KW-1:0] kk, input logic [W-1:0] oo,
                            input logic [W-1:0] r0, input logic o0,
                            input logic [W-1:0] r1, input logic o1);
      int lat;
      bit bok;
      run_req(kk, oo, lat, bok);
      chk({nm, ".lat"},  64'(lat), 64'(int'(kk) + 2));
      chk({nm, ".busy"}, 64'(bok), 64'd1);
      chk({nm, ".res0"}, 64'(res0), 64'(r0));
      chk({nm, ".ovf0"}, 64'(ovf0), 64'(o0));
      chk({nm, ".res1"}, 64'(res1), 64'(r1));
      chk({nm, ".ovf1"}, 64'(ovf1), 64'(o1));
      @(negedge clk);  // leave the done cycle; next request lands one cycle after done
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      vec_t tbl[6];
      logic [W-1:0] e0, e1;
      logic eo0, eo1;
      int cyc;

      tbl[0] = '{6'd2,  32'd0,          32'd1,          1'b0, 32'd1,          1'b0};
      tbl[1] = '{6'd0,  -32'sd5,        -32'sd5,        1'b0, -32'sd5,        1'b0};
      tbl[2] = '{6'd1,  32'd7,          32'd8,          1'b0, 32'd8,          1'b0};
      tbl[3] = '{6'd46, 32'd0,          32'd1836311903, 1'b0, 32'd1836311903, 1'b0};
      tbl[4] = '{6'd47, 32'd0,          32'hB11924E1,   1'b1, 32'h7FFFFFFF,   1'b1};
      tbl[5] = '{6'd10, 32'h7FFFFFF0,   32'h80000027,   1'b1, 32'h7FFFFFFF,   1'b1};

      rst = 1'b1; start = 1'b0; k_i = '0; off_i = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("reset.busy", 64'({busy0, busy1}), 64'd0);
      chk("reset.done", 64'({done0, done1}), 64'd0);
      chk("reset.res",  64'(res0 | res1),    64'd0);
      chk("reset.ovf",  64'({ovf0, ovf1}),   64'd0);

      for (int i = 0; i < 6; i++)
         check_req($sformatf("tbl%0d", i), tbl[i].k, tbl[i].off,
                   tbl[i].r0, tbl[i].o0, tbl[i].r1, tbl[i].o1);

      // start re-pulsed mid-RUN with different operands must be ignored
      k_i = 6'd10; off_i = 32'd3; start = 1'b1;
      @(negedge clk);
      start = 1'b0; cyc = 1;
      repeat (3) begin @(negedge clk); cyc++; end
      k_i = 6'd2; off_i = 32'd100; start = 1'b1;
      @(negedge clk); cyc++;
      start = 1'b0; k_i = 6'd7; off_i = 32'd200;
      while (!done0 && cyc < 200) begin @(negedge clk); cyc++; end
      chk("midrun.lat", 64'(cyc), 64'd12);
      chk("midrun.res", 64'(res0), 64'd58);
      // start held only in the DONE cycle is dropped too
      k_i = 6'd0; off_i = 32'd9; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("donestart.busy", 64'(busy0), 64'd0);
      @(negedge clk);
      chk("donestart.idle", 64'({busy0, done0}), 64'd0);
      chk("donestart.res",  64'(res0), 64'd58);

      // reset in the middle of a long run abandons it silently
      k_i = 6'd20; off_i = 32'd0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rstmid.busy", 64'({busy0, busy1}), 64'd0);
      chk("rstmid.res",  64'(res0), 64'd0);
      chk("rstmid.ovf",  64'({ovf0, ovf1}), 64'd0);
      cyc = 0;
      for (int i = 0; i < 25; i++) begin
         @(negedge clk);
         if (done0 || done1 || busy0) cyc++;
      end
      chk("rstmid.nodone", 64'(cyc), 64'd0);
      check_req("after_rst", 6'd5, 32'd0, 32'd5, 1'b0, 32'd5, 1'b0);

      // randomized requests against the arithmetic model
      for (int i = 0; i < 40; i++) begin
         logic [KW-1:0] rk;
         logic [W-1:0]  ro;
         rk = KW'($urandom_range(0, 63));
         case ($urandom_range(0, 2))
            0:       ro = $urandom;
            1:       ro = 32'h7FFF_FF00 + 32'($urandom_range(0, 255));
            default: ro = 32'h8000_0000 + 32'($urandom_range(0, 255));
         endcase
         model(rk, ro, 1'b0, e0, eo0);
         model(rk, ro, 1'b1, e1, eo1);
         check_req($sformatf("rnd%0d_k%0d", i, rk), rk, ro, e0, eo0, e1, eo1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
